// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Summary  : Single-port video RAM arbiter. Video reads pass straight through;
//            CPU accesses wait in a one-entry hold register for a free cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int STALL_W = 8
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               vid_en,
  input  logic [15:0]        vid_addr,
  output logic [7:0]         vid_din,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  output logic [STALL_W-1:0] stall_count,
  output logic               ram_en,
  output logic               ram_we,
  output logic [15:0]        ram_addr,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 hold_we_q, hold_we_d;
  logic [15:0]          hold_addr_q, hold_addr_d;
  logic [7:0]           hold_wdata_q, hold_wdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic [7:0]           cpu_rdata_q, cpu_rdata_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 cpu_issue;

  always_comb begin
    state_d      = state_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    stall_d      = stall_q;
    cpu_issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The ack cycle must not re-accept the request that is just finishing.
        if (cpu_req && !cpu_ack_q) begin
          hold_we_d    = cpu_we;
          hold_addr_d  = cpu_addr;
          hold_wdata_d = cpu_wdata;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!vid_en) begin
          cpu_issue = 1'b1;
          state_d   = ST_CAPT;
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + STALL_ONE;
        end
      end
      ST_CAPT: begin
        if (!hold_we_q) begin
          cpu_rdata_d = ram_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pending access caught by reset must never reach the RAM.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = hold_addr_q;
    ram_wdata = 8'h00;
    if (vid_en) begin
      ram_en   = 1'b1;
      ram_addr = vid_addr;
    end else if (cpu_issue && !reset) begin
      ram_en    = 1'b1;
      ram_we    = hold_we_q;
      ram_addr  = hold_addr_q;
      ram_wdata = hold_wdata_q;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= 16'h0000;
      hold_wdata_q <= 8'h00;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      stall_q      <= stall_d;
    end
  end

  assign vid_din     = ram_rdata;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign stall_count = stall_q;

endmodule
`default_nettype wire
